// File: rtl/float_add_arb.sv
// float_add_arb
// Shares one pipelined single-precision float adder (fixed latency LAT,
// one new operation accepted per cycle) among N_REQ requesters.
// A round-robin arbiter picks at most one operand pair per cycle. A tag
// pipeline that runs alongside the adder remembers which requester owns
// each in-flight add, so every sum is routed back to its owner.
// Ports:
//   clk, rst        clock (posedge) and synchronous active-high reset
//   req_valid/ready per-requester handshake, ready is a one-hot grant
//   req_din1/2      packed operands, requester i at [32i+31:32i]
//   add_din1/2, add_din_valid   registered issue towards the adder
//   add_dout, add_dout_valid    result coming back from the adder
//   rsp_valid       one-hot owner of the sum on rsp_dout
//   rsp_dout        registered sum, shared by all requesters
//   busy            any operation still in flight
//   err             sticky: adder output disagreed with the tag pipe
module float_add_arb #(
  parameter int N_REQ   = 4,
  parameter int LAT     = 6,
  parameter int MAX_OUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [32*N_REQ-1:0] req_din1,
  input  logic [32*N_REQ-1:0] req_din2,
  output logic [31:0]         add_din1,
  output logic [31:0]         add_din2,
  output logic                add_din_valid,
  input  logic [31:0]         add_dout,
  input  logic                add_dout_valid,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_dout,
  output logic                busy,
  output logic                err
);

  localparam int         ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [3:0]       cnt_q [N_REQ];
  logic [3:0]       cnt_d [N_REQ];
  logic             add_din_valid_q, add_din_valid_d;
  logic [31:0]      add_din1_q, add_din1_d;
  logic [31:0]      add_din2_q, add_din2_d;
  logic [ID_W-1:0]  tag_in_q, tag_in_d;
  logic [LAT-1:0]   tag_v_q, tag_v_d;
  logic [ID_W-1:0]  tag_id_q [LAT];
  logic [ID_W-1:0]  tag_id_d [LAT];
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dout_q, rsp_dout_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             hs;
  logic             tail_v;
  logic [ID_W-1:0]  tail_id;
  logic             underflow;

  // Round-robin scan. Walking from the farthest offset back to the pointer
  // lets the closest eligible requester overwrite any earlier pick.
  // A requester that already has MAX_OUT adds in flight is skipped.
  always_comb begin
    int idx;
    idx      = 0;
    eligible = '0;
    grant    = '0;
    grant_id = '0;
    hs       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] != MAX_CNT);
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (eligible[idx] && !rst) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        hs         = 1'b1;
      end
    end
  end

  // Issue stage and pointer update. Operands hold while idle so the adder
  // inputs only toggle on real issues.
  always_comb begin
    add_din_valid_d = hs;
    add_din1_d      = add_din1_q;
    add_din2_d      = add_din2_q;
    tag_in_d        = tag_in_q;
    ptr_d           = ptr_q;
    if (hs) begin
      add_din1_d = req_din1[int'(grant_id)*32 +: 32];
      add_din2_d = req_din2[int'(grant_id)*32 +: 32];
      tag_in_d   = grant_id;
      ptr_d      = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipe: one stage per adder cycle, so the last stage describes
  // whatever the adder presents on add_dout this cycle.
  always_comb begin
    tag_v_d     = '0;
    tag_id_d[0] = tag_in_q;
    tag_v_d[0]  = add_din_valid_q;
    for (int k = 1; k < LAT; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end
  end

  assign tail_v  = tag_v_q[LAT-1];
  assign tail_id = tag_id_q[LAT-1];

  // Response routing, outstanding counters and error detection. A result
  // without a matching tag (or a missing result) is never delivered.
  always_comb begin
    rsp_valid_d = '0;
    rsp_dout_d  = rsp_dout_q;
    underflow   = 1'b0;
    if (add_dout_valid) begin
      rsp_dout_d = add_dout;
      if (tail_v) begin
        rsp_valid_d[tail_id] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !rsp_valid_q[i]) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (rsp_valid_q[i] && !grant[i]) begin
        if (cnt_q[i] == 4'd0) begin
          underflow = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 4'd1;
        end
      end
    end
    err_d = err_q || (add_dout_valid != tail_v) || underflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q           <= '0;
      add_din_valid_q <= 1'b0;
      add_din1_q      <= '0;
      add_din2_q      <= '0;
      tag_in_q        <= '0;
      tag_v_q         <= '0;
      rsp_valid_q     <= '0;
      rsp_dout_q      <= '0;
      err_q           <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      for (int k = 0; k < LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      ptr_q           <= ptr_d;
      add_din_valid_q <= add_din_valid_d;
      add_din1_q      <= add_din1_d;
      add_din2_q      <= add_din2_d;
      tag_in_q        <= tag_in_d;
      tag_v_q         <= tag_v_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_dout_q      <= rsp_dout_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      tag_id_q        <= tag_id_d;
    end
  end

  assign req_ready     = grant;
  assign add_din_valid = add_din_valid_q;
  assign add_din1      = add_din1_q;
  assign add_din2      = add_din2_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_dout      = rsp_dout_q;
  assign err           = err_q;
  assign busy          = (|tag_v_q) | add_din_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_float_add_arb.sv
// tb_float_add_arb
// Drives float_add_arb with directed and random requester traffic and a
// stand-in LAT-cycle float adder. A behavioural model (round-robin pointer,
// per-requester outstanding counts, per-requester FIFOs of expected sums
// and a fixed-latency list of grants) predicts every output each cycle.
module tb_float_add_arb;

  localparam int N_REQ   = 4;
  localparam int LAT     = 6;
  localparam int MAX_OUT = 8;
  localparam int DEPTH   = LAT + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid, req_ready, rsp_valid;
  logic [32*N_REQ-1:0] req_din1, req_din2;
  logic [31:0]         add_din1, add_din2, add_dout, rsp_dout;
  logic                add_din_valid, add_dout_valid, busy, err;
  logic                force_dv;

  int checks = 0;
  int errors = 0;

  // Model state
  int          ptr_m;
  int          outstanding [N_REQ];
  logic [31:0] sums [N_REQ][$];
  bit          line_v [DEPTH];
  int          line_id [DEPTH];
  bit          err_m;

  // Outputs as sampled in the most recent checked cycle
  logic [N_REQ-1:0] s_ready, s_rsp;
  logic [31:0]      s_dout;
  logic             s_busy, s_err;

  always #5 clk = ~clk;

  float_add_arb #(.N_REQ(N_REQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_din1      (req_din1),
    .req_din2      (req_din2),
    .add_din1      (add_din1),
    .add_din2      (add_din2),
    .add_din_valid (add_din_valid),
    .add_dout      (add_dout),
    .add_dout_valid(add_dout_valid),
    .rsp_valid     (rsp_valid),
    .rsp_dout      (rsp_dout),
    .busy          (busy),
    .err           (err)
  );

  // Single-precision normal number to real, via the double bit layout.
  function automatic real toReal(input logic [31:0] f);
    logic [63:0] d;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Float add used both by the stand-in adder and by the expected values.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real         rs;
    logic [63:0] d;
    rs = toReal(a) + toReal(b);
    if (rs == 0.0) return 32'h0;
    d = $realtobits(rs);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] randFloat();
    return {1'($urandom), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
  endfunction

  // Stand-in adder: fixed latency, cleared by reset (its nrst is ~rst).
  logic [LAT-1:0] ad_v;
  logic [31:0]    ad_a [LAT];
  logic [31:0]    ad_b [LAT];

  always @(posedge clk) begin
    if (rst) begin
      ad_v <= '0;
    end else begin
      ad_v    <= {ad_v[LAT-2:0], add_din_valid};
      ad_a[0] <= add_din1;
      ad_b[0] <= add_din2;
      for (int k = 1; k < LAT; k++) begin
        ad_a[k] <= ad_a[k-1];
        ad_b[k] <= ad_b[k-1];
      end
    end
  end

  assign add_dout_valid = ad_v[LAT-1] | force_dv;
  assign add_dout       = fadd(ad_a[LAT-1], ad_b[LAT-1]);

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Requester the model would grant now, -1 when nobody is eligible.
  function automatic int modelGrant();
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (ptr_m + k) % N_REQ;
      if (req_valid[i] && outstanding[i] < MAX_OUT) return i;
    end
    return -1;
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    int               g;
    logic [N_REQ-1:0] exp_ready, exp_rsp;
    logic             exp_busy;
    s_ready = req_ready;
    s_rsp   = rsp_valid;
    s_dout  = rsp_dout;
    s_busy  = busy;
    s_err   = err;
    g = modelGrant();
    exp_ready = '0;
    if (!rst && g >= 0) exp_ready[g] = 1'b1;
    exp_rsp = '0;
    if (line_v[LAT+1]) exp_rsp[line_id[LAT+1]] = 1'b1;
    exp_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_busy |= line_v[k];
    checkValue("req_ready", 32'(req_ready), 32'(exp_ready));
    checkValue("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (line_v[LAT+1]) checkValue("rsp_dout", rsp_dout, sums[line_id[LAT+1]][0]);
    checkValue("busy", 32'(busy), 32'(exp_busy));
    checkValue("err", 32'(err), 32'(err_m));
  endtask

  // Advance the model across one rising edge.
  task automatic updateModel();
    int g;
    if (rst) begin
      ptr_m = 0;
      err_m = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        outstanding[i] = 0;
        sums[i].delete();
      end
      for (int k = 0; k < DEPTH; k++) begin
        line_v[k]  = 1'b0;
        line_id[k] = 0;
      end
      return;
    end
    g = modelGrant();
    if (force_dv && !line_v[LAT]) err_m = 1'b1;
    if (line_v[LAT+1]) begin
      outstanding[line_id[LAT+1]]--;
      void'(sums[line_id[LAT+1]].pop_front());
    end
    for (int k = DEPTH - 1; k > 0; k--) begin
      line_v[k]  = line_v[k-1];
      line_id[k] = line_id[k-1];
    end
    line_v[0]  = (g >= 0);
    line_id[0] = (g >= 0) ? g : 0;
    if (g >= 0) begin
      outstanding[g]++;
      sums[g].push_back(fadd(req_din1[32*g +: 32], req_din2[32*g +: 32]));
      ptr_m = (g + 1) % N_REQ;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] v);
    req_valid = v;
    for (int i = 0; i < N_REQ; i++) begin
      req_din1[32*i +: 32] = randFloat();
      req_din2[32*i +: 32] = randFloat();
    end
  endtask

  task automatic resetCycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends even if the clock loop stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    force_dv = 1'b0;
    req_din1 = '0;
    req_din2 = '0;
    req_valid = '1;
    @(posedge clk);
    updateModel();
    #1;

    // Reset state: ready held low while rst is high even with all valid.
    cycle();
    checkValue("rst_ready", 32'(s_ready), 32'h0);
    checkValue("rst_busy", 32'(s_busy), 32'h0);
    checkValue("rst_err", 32'(s_err), 32'h0);
    rst = 1'b0;
    applyStimulus('0);
    cycle();

    // Single op from requester 0: 1.5 + 2.25 = 3.75 after 8 cycles.
    applyStimulus(4'b0001);
    req_din1[31:0] = 32'h3FC00000;
    req_din2[31:0] = 32'h40100000;
    cycle();
    applyStimulus('0);
    for (int n = 1; n <= 8; n++) begin
      cycle();
      if (n == 7) checkValue("single_rsp_early", 32'(s_rsp), 32'h0);
    end
    checkValue("single_rsp_valid", 32'(s_rsp), 32'h1);
    checkValue("single_rsp_dout", s_dout, 32'h40700000);
    cycle();
    checkValue("single_idle_busy", 32'(s_busy), 32'h0);
    applyStimulus(4'b0001);
    cycle();
    checkValue("single_cnt_back", 32'(s_ready), 32'h1);
    applyStimulus('0);
    repeat (10) cycle();

    // All four requesters valid continuously from pointer 0.
    resetCycle();
    for (int n = 0; n < 16; n++) begin
      applyStimulus('1);
      cycle();
      checkValue("rr_order", 32'(s_ready), 32'(1 << (n % 4)));
    end
    applyStimulus('0);
    repeat (10) cycle();

    // Requester 1 alone saturates at MAX_OUT outstanding operations.
    resetCycle();
    for (int n = 0; n < 14; n++) begin
      applyStimulus(4'b0010);
      cycle();
      if (n < 8)  checkValue("max_out_ready", 32'(s_ready), 32'h2);
      if (n == 8) checkValue("max_out_stall", 32'(s_ready), 32'h0);
      if (n == 8) checkValue("max_out_first_rsp", 32'(s_rsp), 32'h2);
      if (n == 9) checkValue("max_out_resume", 32'(s_ready), 32'h2);
    end
    applyStimulus('0);
    repeat (10) cycle();

    // Random traffic; requester 3 stays idle in the first half.
    for (int n = 0; n < 300; n++) begin
      logic [N_REQ-1:0] v;
      v = N_REQ'($urandom);
      if (n < 150) v[3] = 1'b0;
      applyStimulus(v);
      cycle();
      if (n < 150) checkValue("idle_req3_no_grant", 32'(s_ready[3]), 32'h0);
    end
    applyStimulus('0);
    repeat (10) cycle();

    // Reset with five operations in flight discards all of them.
    for (int n = 0; n < 5; n++) begin
      applyStimulus('1);
      cycle();
    end
    resetCycle();
    applyStimulus('0);
    for (int n = 0; n < 12; n++) begin
      cycle();
      checkValue("flush_no_rsp", 32'(s_rsp), 32'h0);
    end
    checkValue("flush_busy", 32'(s_busy), 32'h0);
    checkValue("flush_err", 32'(s_err), 32'h0);
    applyStimulus('1);
    cycle();
    checkValue("flush_ptr_zero", 32'(s_ready), 32'h1);
    applyStimulus('0);
    repeat (10) cycle();

    // Spurious adder output with an empty tail raises a sticky error.
    force_dv = 1'b1;
    cycle();
    force_dv = 1'b0;
    cycle();
    checkValue("err_set", 32'(s_err), 32'h1);
    checkValue("err_no_rsp", 32'(s_rsp), 32'h0);
    repeat (5) cycle();
    checkValue("err_sticky", 32'(s_err), 32'h1);
    resetCycle();
    cycle();
    checkValue("err_cleared", 32'(s_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
